rx_cmd_decoder: RTL

- Sits directly downstream of the multi-bit data synchronizer.
- Consumes its sync_bus byte stream, qualified by the one-cycle enable_pulse, and parses framed commands.
- Issues register-file write and read strobes; returns read data to the transmit path over a valid/busy handshake.
- Single clock domain: the synchronizer's destination clock.

---
 rtl/rx_cmd_decoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rx_cmd_decoder.sv
// rtl/rx_cmd_decoder.sv - framed command parser between rx synchronizer, register file and tx path
// Write frame: WR_CMD, addr, data. Read frame: RD_CMD, addr; read data returned over tx handshake.
module rx_cmd_decoder #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
  parameter int                    RD_TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic                  cmd_error,
  output logic                  rx_overrun,
  output logic                  busy
);

  localparam int                CNT_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wr_data_n, tx_data_n;
  logic                  tx_valid_n, wr_en_n, rd_en_n, err_n, ovr_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      cmd_error  <= 1'b0;
      rx_overrun <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rf_addr    <= addr_n;
      rf_wr_data <= wr_data_n;
      rf_wr_en   <= wr_en_n;
      rf_rd_en   <= rd_en_n;
      tx_data    <= tx_data_n;
      tx_valid   <= tx_valid_n;
      cmd_error  <= err_n;
      rx_overrun <= ovr_n;
      busy       <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = rf_addr;
    wr_data_n  = rf_wr_data;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    wr_en_n    = 1'b0;
    rd_en_n    = 1'b0;
    err_n      = 1'b0;
    ovr_n      = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == WR_CMD)      state_n = WR_ADDR;
          else if (rx_data == RD_CMD) state_n = RD_ADDR;
          else                        err_n   = 1'b1;
        end
      end
      WR_ADDR: begin
        if (rx_valid) begin
          addr_n  = rx_data[ADDR_WIDTH-1:0];
          state_n = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          wr_data_n = rx_data;
          wr_en_n   = 1'b1;
          state_n   = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_valid) begin
          addr_n  = rx_data[ADDR_WIDTH-1:0];
          rd_en_n = 1'b1;
          cnt_n   = '0;
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        ovr_n = rx_valid;
        // Data arriving on the expiry cycle still wins over the timeout.
        if (rf_rd_valid) begin
          tx_data_n  = rf_rd_data;
          tx_valid_n = 1'b1;
          state_n    = TX_SEND;
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      TX_SEND: begin
        ovr_n = rx_valid;
        if (!tx_busy) begin
          tx_valid_n = 1'b0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
